fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. It holds the PC, drives the instruction-memory address, and selects the next PC from the `pcsrc` code resolved by the ID-stage branch comparator. It also computes the branch and jump targets from its own IF/ID contents. It applies hazard-unit stalls and squashes the wrong-path instruction after a taken control transfer.

---
 rtl/mips_pkg.sv | 12 +
 rtl/pc_reg.sv | 23 ++
 rtl/fetch_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: word type, next-PC select codes, NOP encoding.
package mips_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;

  localparam word_t NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Enable-gated 32-bit register with asynchronous active-low reset to RESET_PC.
module pc_reg
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_3000
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  word_t d,
  output word_t q
);

  // Load d when enabled; reset forces the boot PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Build option: FETCH_DELAY_SLOT_EN keeps the instruction after a taken
// branch/jump (MIPS delay slot) instead of squashing it to a bubble.
module fetch_stage
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pc_plus4D,
  output logic        validD
);

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit FLUSH_EN = 1'b0;
`else
  localparam bit FLUSH_EN = 1'b1;
`endif

  word_t             pc_plus4F;
  logic signed [31:0] branch_off;
  word_t             branch_target;
  word_t             jump_target;
  logic [1:0]        sel;
  word_t             pc_next;
  logic              redirect;

  assign pc_plus4F     = pcF + 32'd4;
  assign branch_off    = {{14{instrD[15]}}, instrD[15:0], 2'b00};
  assign branch_target = pc_plus4D + word_t'(branch_off);
  assign jump_target   = {pc_plus4D[31:28], instrD[25:0], 2'b00};

  // Effective select: stalled ID or a bubble never steers the PC; 11 acts as jump.
  always_comb begin
    sel = PCSRC_SEQ;
    if (!stallD && validD) begin
      if (pcsrc[0]) sel = PCSRC_JUMP;
      else          sel = pcsrc;
    end
  end

  assign redirect = (sel != PCSRC_SEQ);

  // Next-PC mux.
  always_comb begin
    pc_next = pc_plus4F;
    case (sel)
      PCSRC_JUMP:   pc_next = jump_target;
      PCSRC_BRANCH: pc_next = branch_target;
      default:      pc_next = pc_plus4F;
    endcase
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stallF),
    .d     (pc_next),
    .q     (pcF)
  );

  // IF/ID register: hold on stallD, squash wrong path on redirect, else advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrD    <= NOP_INSTR;
      pc_plus4D <= RESET_PC;
      validD    <= 1'b0;
    end else if (!stallD) begin
      if (redirect && FLUSH_EN) begin
        instrD    <= NOP_INSTR;
        pc_plus4D <= pc_plus4F;
        validD    <= 1'b0;
      end else begin
        instrD    <= instrF;
        pc_plus4D <= pc_plus4F;
        validD    <= 1'b1;
      end
    end
  end

endmodule
